// File: rtl/thor2022_pkg.sv
// Shared types and geometry for the Thor2022 instruction-cache fill path.
// A line is four 16-byte beats; the way field is fixed at two bits.
package thor2022_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

    localparam int BEAT_W     = 2;
    localparam int WAY_W      = 2;
    localparam int BEAT_BYTES = 16;
    localparam int LINE_BYTES = 64;
    localparam int BEAT_BITS  = BEAT_BYTES * 8;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int BEAT_OFS   = $clog2(BEAT_BYTES);
    localparam int LINE_OFS   = $clog2(LINE_BYTES);

endpackage

// File: rtl/thor2022_icvictim.sv
// Per-set round-robin victim pointers: combinational read by set index,
// and a one-cycle advance strobe that bumps one set's pointer modulo WAYS.
module thor2022_icvictim
    import thor2022_pkg::*;
#(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int SET_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SET_W-1:0] rd_set,
    output logic [WAY_W-1:0] rd_way,
    input  logic             adv,
    input  logic [SET_W-1:0] adv_set
);

    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] ptr [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                ptr[i] <= '0;
            end
        end else if (adv) begin
            ptr[adv_set] <= (ptr[adv_set] == LAST_WAY) ? '0 : ptr[adv_set] + 1'b1;
        end
    end

    assign rd_way = ptr[rd_set];

endmodule

// File: rtl/thor2022_icfill.sv
// Instruction-cache line fill: fetches four beats for a missing line, then
// issues one tag/data write to the victim way chosen by round-robin.
module thor2022_icfill
    import thor2022_pkg::*;
#(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int AWID  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss,
    input  logic [AWID-1:0]      miss_adr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mreq,
    output logic [AWID-1:0]      madr,
    input  logic                 mack,
    input  logic                 merr,
    input  logic [BEAT_BITS-1:0] mdat,
    output logic                 tag_wr,
    output logic [AWID-1:0]      tag_ip,
    output logic [WAY_W-1:0]     tag_way,
    output logic                 line_wr,
    output logic [LINE_BITS-1:0] line_dat
);

    localparam int SET_W = $clog2(LINES);
    localparam int LA_W  = AWID - LINE_OFS;

    fill_state_e      state, state_nx;
    logic [LA_W-1:0]  line_q;
    logic [BEAT_W-1:0] beat_q;
    logic [WAY_W-1:0] way_q;
    logic [WAY_W-1:0] vic_way;
    logic             accept;
    logic             beat_ok;
    logic             beat_bad;
    logic             unused_adr;

    // Memory handshake: mreq is a level request held for the whole FETCH;
    // every cycle with mack=1 transfers exactly one beat at madr, and merr
    // is only meaningful in a cycle where mack=1.
    assign accept   = (state == IDLE) && miss;
    assign beat_ok  = (state == FETCH) && mack && !merr;
    assign beat_bad = (state == FETCH) && mack && merr;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (miss) state_nx = FETCH;
            FETCH: begin
                if (beat_bad) begin
                    state_nx = IDLE;
                end else if (beat_ok && (beat_q == 2'd3)) begin
                    state_nx = WRITE;
                end
            end
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            line_q   <= '0;
            beat_q   <= '0;
            way_q    <= '0;
            line_dat <= '0;
            tag_wr   <= 1'b0;
            line_wr  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_nx;
            tag_wr  <= (state == WRITE);
            line_wr <= (state == WRITE);
            done    <= (state == DONE);
            err     <= beat_bad;
            if (accept) begin
                line_q <= miss_adr[AWID-1:LINE_OFS];
                beat_q <= '0;
                way_q  <= vic_way;
            end else if (beat_ok) begin
                line_dat[beat_q*BEAT_BITS +: BEAT_BITS] <= mdat;
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    // The pointer is sampled when the miss is accepted and advanced only on a
    // completed fill, so an aborted fill leaves the set's victim unchanged.
    thor2022_icvictim #(
        .LINES (LINES),
        .WAYS  (WAYS),
        .SET_W (SET_W)
    ) u_victim (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_set  (miss_adr[LINE_OFS +: SET_W]),
        .rd_way  (vic_way),
        .adv     (state == WRITE),
        .adv_set (line_q[SET_W-1:0])
    );

    assign busy    = (state != IDLE);
    assign mreq    = (state == FETCH);
    assign madr    = {line_q, beat_q, {BEAT_OFS{1'b0}}};
    assign tag_ip  = {line_q, {LINE_OFS{1'b0}}};
    assign tag_way = way_q;

    assign unused_adr = ^miss_adr[LINE_OFS-1:0];

endmodule

// File: tb/tb_thor2022_icfill.sv
// Bench for thor2022_icfill: random beats and wait states checked against a
// line/round-robin model computed from byte addresses.
module tb_thor2022_icfill;

    localparam int AWID = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            miss = 1'b0;
    logic [AWID-1:0] miss_adr = '0;
    logic            mack = 1'b0;
    logic            merr = 1'b0;
    logic [127:0]    mdat = '0;
    logic            busy, done, err, mreq, tag_wr, line_wr;
    logic [AWID-1:0] madr, tag_ip;
    logic [1:0]      tag_way;
    logic [511:0]    line_dat;

    thor2022_icfill #(.LINES(128), .WAYS(4), .AWID(AWID)) dut (
        .clk(clk), .rst_n(rst_n), .miss(miss), .miss_adr(miss_adr),
        .busy(busy), .done(done), .err(err), .mreq(mreq), .madr(madr),
        .mack(mack), .merr(merr), .mdat(mdat), .tag_wr(tag_wr),
        .tag_ip(tag_ip), .tag_way(tag_way), .line_wr(line_wr), .line_dat(line_dat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [AWID-1:0] exp_q[$];
    logic [AWID-1:0] obs_madr[$];
    int              ptr_m[128];
    logic [127:0]    beat_dat[4];

    int              obs_tagwr_cnt, obs_tagwr_edge, obs_done_cnt, obs_done_edge;
    int              obs_err_cnt, obs_lw_mis, obs_mreq_gap, obs_waits;
    logic            obs_mreq_after_err;
    logic [AWID-1:0] obs_tag_ip;
    logic [1:0]      obs_tag_way;
    logic [511:0]    obs_line;
    bit              obs_timeout;

    // ---------------- reference model ----------------
    function automatic logic [AWID-1:0] line_base(input logic [AWID-1:0] a);
        return a & ~32'h3F;
    endfunction

    function automatic int set_of(input logic [AWID-1:0] a);
        return int'((a / 64) % 128);
    endfunction

    function automatic logic [1:0] take_way(input int s);
        int w;
        w = ptr_m[s];
        ptr_m[s] = (w + 1) % 4;
        return 2'(w);
    endfunction

    function automatic logic [511:0] exp_line();
        return {beat_dat[3], beat_dat[2], beat_dat[1], beat_dat[0]};
    endfunction

    task automatic build_exp_madr(input logic [AWID-1:0] a, input int n);
        exp_q.delete();
        for (int b = 0; b < n; b++) exp_q.push_back(line_base(a) + 32'(16 * b));
    endtask

    task automatic random_beats();
        for (int b = 0; b < 4; b++) beat_dat[b] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // ---------------- clock/reset and driver ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        miss = 1'b0; mack = 1'b0; merr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) ptr_m[i] = 0;
    endtask

    // Edge numbering: the rising edge that accepts the miss is edge 1.
    task automatic run_fill(input logic [AWID-1:0] adr, input int min_wait, input int max_wait,
                            input int err_beat, input bit hold_miss, input bit skip_start,
                            input int pulse_cyc);
        int edge_cnt, cyc, beat, wait_left;
        bit fin, aborted;
        obs_madr.delete();
        obs_tagwr_cnt = 0; obs_tagwr_edge = 0; obs_done_cnt = 0; obs_done_edge = 0;
        obs_err_cnt = 0; obs_lw_mis = 0; obs_mreq_gap = 0; obs_waits = 0;
        obs_mreq_after_err = 1'b1; obs_tag_ip = '0; obs_tag_way = '0; obs_line = '0;
        if (!skip_start) begin
            @(negedge clk);
            miss = 1'b1;
            miss_adr = adr;
            @(posedge clk);
        end
        edge_cnt = 1; cyc = 0; beat = 0; fin = 0; aborted = 0;
        wait_left = $urandom_range(max_wait, min_wait);
        obs_waits += wait_left;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold_miss) miss = (cyc == pulse_cyc);
            if (cyc == pulse_cyc) miss_adr = $urandom;
            if (line_wr !== tag_wr) obs_lw_mis++;
            if (tag_wr === 1'b1) begin
                obs_tagwr_cnt++;
                obs_tagwr_edge = edge_cnt;
                obs_tag_ip = tag_ip;
                obs_tag_way = tag_way;
                obs_line = line_dat;
            end
            if (done === 1'b1) begin
                obs_done_cnt++;
                obs_done_edge = edge_cnt;
                fin = 1;
            end
            if (err === 1'b1) begin
                obs_err_cnt++;
                obs_mreq_after_err = mreq;
                fin = 1;
            end
            mack = 1'b0;
            merr = 1'b0;
            if (beat < 4 && !aborted) begin
                if (mreq !== 1'b1) obs_mreq_gap++;
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    mack = 1'b1;
                    mdat = beat_dat[beat];
                    merr = (beat == err_beat);
                    obs_madr.push_back(madr);
                    if (beat == err_beat) aborted = 1;
                    beat++;
                    if (beat < 4 && !aborted) begin
                        wait_left = $urandom_range(max_wait, min_wait);
                        obs_waits += wait_left;
                    end
                end
            end
            @(posedge clk);
            edge_cnt++;
        end
        mack = 1'b0;
        merr = 1'b0;
        if (!hold_miss) miss = 1'b0;
        obs_timeout = !fin;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (mreq !== 1'b0) begin failures++; $display("FAIL reset_mreq got=%b exp=0", mreq); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
        checks++; if (tag_wr !== 1'b0 || line_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b%b exp=00", tag_wr, line_wr); end
        checks++; if (madr !== '0 || tag_ip !== '0) begin failures++; $display("FAIL reset_adr madr=%h tag_ip=%h exp=0", madr, tag_ip); end
        checks++; if (tag_way !== 2'd0) begin failures++; $display("FAIL reset_way got=%0d exp=0", tag_way); end
        checks++; if (line_dat !== '0) begin failures++; $display("FAIL reset_line got=%h exp=0", line_dat); end
    endtask

    task automatic test_basic();
        logic [1:0] ew;
        logic [AWID-1:0] e, o;
        random_beats();
        ew = take_way(set_of(32'h0000_1234));
        build_exp_madr(32'h0000_1234, 4);
        run_fill(32'h0000_1234, 0, 0, -1, 0, 0, 0);
        checks++; if (obs_timeout) begin failures++; $display("FAIL basic_timeout got=none exp=done"); end
        checks++; if (obs_madr.size() != 4) begin failures++; $display("FAIL basic_beats got=%0d exp=4", obs_madr.size()); end
        while (exp_q.size() > 0 && obs_madr.size() > 0) begin
            e = exp_q.pop_front(); o = obs_madr.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL basic_madr got=%h exp=%h", o, e); end
        end
        checks++; if (obs_tagwr_cnt != 1) begin failures++; $display("FAIL basic_tagwr_cnt got=%0d exp=1", obs_tagwr_cnt); end
        checks++; if (obs_tag_ip !== 32'h0000_1200) begin failures++; $display("FAIL basic_tag_ip got=%h exp=00001200", obs_tag_ip); end
        checks++; if (obs_tag_way !== ew) begin failures++; $display("FAIL basic_tag_way got=%0d exp=%0d", obs_tag_way, ew); end
        checks++; if (obs_tagwr_edge != 6) begin failures++; $display("FAIL basic_tagwr_latency got=%0d exp=6", obs_tagwr_edge); end
        checks++; if (obs_done_edge != 7 || obs_done_cnt != 1) begin failures++; $display("FAIL basic_done got=%0d@%0d exp=1@7", obs_done_cnt, obs_done_edge); end
        checks++; if (obs_lw_mis != 0) begin failures++; $display("FAIL basic_line_wr got=%0d exp=0", obs_lw_mis); end
        checks++; if (obs_line !== exp_line()) begin failures++; $display("FAIL basic_line got=%h exp=%h", obs_line, exp_line()); end
    endtask

    task automatic test_back_to_back();
        logic [AWID-1:0] a;
        logic [1:0] ew;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            a = ($urandom & ~32'h1FC0) | (32'h48 << 6);
            random_beats();
            ew = take_way(8'h48);
            run_fill(a, 0, 0, -1, 0, 0, 0);
            checks++; if (obs_tag_way !== ew || obs_tagwr_cnt != 1) begin failures++; $display("FAIL b2b_way fill=%0d got=%0d exp=%0d", k, obs_tag_way, ew); end
            checks++; if (obs_tag_ip !== line_base(a)) begin failures++; $display("FAIL b2b_tag_ip got=%h exp=%h", obs_tag_ip, line_base(a)); end
        end
    endtask

    task automatic test_bus_error();
        logic [AWID-1:0] a;
        logic [1:0] ew;
        int s, extra;
        a = $urandom;
        s = set_of(a);
        ew = 2'(ptr_m[s]);
        random_beats();
        run_fill(a, 0, 1, 2, 0, 0, 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (err === 1'b1 || tag_wr === 1'b1 || line_wr === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (obs_err_cnt != 1 || extra != 0) begin failures++; $display("FAIL err_pulse got=%0d extra=%0d exp=1", obs_err_cnt, extra); end
        checks++; if (obs_tagwr_cnt != 0 || obs_lw_mis != 0 || obs_done_cnt != 0) begin failures++; $display("FAIL err_no_write tag_wr=%0d done=%0d exp=0", obs_tagwr_cnt, obs_done_cnt); end
        checks++; if (obs_mreq_after_err !== 1'b0) begin failures++; $display("FAIL err_mreq_drop got=%b exp=0", obs_mreq_after_err); end
        checks++; if (obs_madr.size() != 3) begin failures++; $display("FAIL err_beats got=%0d exp=3", obs_madr.size()); end
        random_beats();
        ew = take_way(s);
        run_fill(a ^ 32'hFFFF_E000, 0, 0, -1, 0, 0, 0);
        checks++; if (obs_tag_way !== ew) begin failures++; $display("FAIL err_way_kept got=%0d exp=%0d", obs_tag_way, ew); end
    endtask

    task automatic test_wait_states();
        logic [AWID-1:0] a;
        a = $urandom;
        beat_dat[0] = {32{4'hA}}; beat_dat[1] = {32{4'hB}};
        beat_dat[2] = {32{4'hC}}; beat_dat[3] = {32{4'hD}};
        void'(take_way(set_of(a)));
        run_fill(a, 2, 2, -1, 0, 0, 0);
        checks++; if (obs_line !== {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}}) begin failures++; $display("FAIL wait_line got=%h", obs_line); end
        checks++; if (obs_mreq_gap != 0) begin failures++; $display("FAIL wait_mreq_gap got=%0d exp=0", obs_mreq_gap); end
        checks++; if (obs_tagwr_edge != 14 || obs_done_edge != 15) begin failures++; $display("FAIL wait_latency got=%0d/%0d exp=14/15", obs_tagwr_edge, obs_done_edge); end
    endtask

    task automatic test_reset_midfetch();
        int bad;
        logic [1:0] ew;
        @(negedge clk);
        miss = 1'b1; miss_adr = 32'h0000_5A40;
        @(posedge clk);
        @(negedge clk);
        miss = 1'b0; mack = 1'b1; mdat = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mreq !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_async mreq=%b busy=%b exp=00", mreq, busy); end
        mack = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tag_wr === 1'b1 || done === 1'b1) bad++;
        end
        rst_n = 1'b1;
        mack = 1'b1;
        for (int i = 0; i < 128; i++) ptr_m[i] = 0;
        @(negedge clk);
        mack = 1'b0;
        checks++; if (busy !== 1'b0 || mreq !== 1'b0 || bad != 0) begin failures++; $display("FAIL rst_release busy=%b mreq=%b writes=%0d exp=0", busy, mreq, bad); end
        checks++; if (line_dat !== '0) begin failures++; $display("FAIL rst_line got=%h exp=0", line_dat); end
        random_beats();
        ew = take_way(8'h48);
        run_fill(32'h0000_1200, 0, 0, -1, 0, 0, 0);
        checks++; if (obs_tag_way !== ew) begin failures++; $display("FAIL rst_ptr_zero got=%0d exp=%0d", obs_tag_way, ew); end
    endtask

    task automatic test_miss_in_fetch();
        logic [AWID-1:0] a;
        int extra;
        a = $urandom;
        random_beats();
        void'(take_way(set_of(a)));
        run_fill(a, 1, 2, -1, 0, 0, 2);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1 || tag_wr === 1'b1) extra++;
        end
        checks++; if (obs_done_cnt != 1 || extra != 0) begin failures++; $display("FAIL fetch_miss_ignored done=%0d extra=%0d exp=1/0", obs_done_cnt, extra); end
        checks++; if (obs_tag_ip !== line_base(a)) begin failures++; $display("FAIL fetch_miss_tag_ip got=%h exp=%h", obs_tag_ip, line_base(a)); end
    endtask

    task automatic test_held_miss();
        logic [AWID-1:0] a;
        logic [1:0] ew;
        a = $urandom;
        random_beats();
        void'(take_way(set_of(a)));
        run_fill(a, 0, 0, -1, 1, 0, 0);
        ew = take_way(set_of(a));
        random_beats();
        run_fill(a, 0, 0, -1, 0, 1, 0);
        checks++; if (obs_tagwr_edge != 6 || obs_tag_way !== ew) begin failures++; $display("FAIL held_refill edge=%0d way=%0d exp=6/%0d", obs_tagwr_edge, obs_tag_way, ew); end
        checks++; if (obs_line !== exp_line()) begin failures++; $display("FAIL held_line got=%h exp=%h", obs_line, exp_line()); end
    endtask

    task automatic test_random();
        logic [AWID-1:0] a, e, o;
        logic [1:0] ew;
        int eb, s, n;
        for (int it = 0; it < 12; it++) begin
            a = ($urandom & ~32'h1FC0) | (32'($urandom_range(3, 0)) << 6);
            s = set_of(a);
            eb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            random_beats();
            n = (eb < 0) ? 4 : eb + 1;
            build_exp_madr(a, n);
            ew = (eb < 0) ? take_way(s) : 2'(ptr_m[s]);
            run_fill(a, 0, 3, eb, 0, 0, 0);
            checks++; if (obs_madr.size() != n || obs_timeout) begin failures++; $display("FAIL rnd_beats got=%0d exp=%0d", obs_madr.size(), n); end
            while (exp_q.size() > 0 && obs_madr.size() > 0) begin
                e = exp_q.pop_front(); o = obs_madr.pop_front();
                checks++; if (o !== e) begin failures++; $display("FAIL rnd_madr got=%h exp=%h", o, e); end
            end
            if (eb < 0) begin
                checks++; if (obs_tag_way !== ew || obs_tag_ip !== line_base(a)) begin failures++; $display("FAIL rnd_tag way=%0d ip=%h exp=%0d/%h", obs_tag_way, obs_tag_ip, ew, line_base(a)); end
                checks++; if (obs_line !== exp_line()) begin failures++; $display("FAIL rnd_line got=%h exp=%h", obs_line, exp_line()); end
                checks++; if (obs_tagwr_edge != 6 + obs_waits || obs_done_edge != 7 + obs_waits) begin failures++; $display("FAIL rnd_latency got=%0d/%0d exp=%0d", obs_tagwr_edge, obs_done_edge, 6 + obs_waits); end
            end else begin
                checks++; if (obs_err_cnt != 1 || obs_tagwr_cnt != 0 || obs_done_cnt != 0) begin failures++; $display("FAIL rnd_err err=%0d tag_wr=%0d done=%0d exp=1/0/0", obs_err_cnt, obs_tagwr_cnt, obs_done_cnt); end
            end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_bus_error();
        test_wait_states();
        test_reset_midfetch();
        test_miss_in_fetch();
        test_held_miss();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/thor2022_icfill.md
THOR2022_ICFILL -- requirements
Module: Thor2022_icfill

Interface
REQ-001 SHALL have parameter LINES, default 128, meaning sets per way; set index is adr[12:6].
REQ-002 SHALL have parameter WAYS, default 4, meaning associativity; way field is 2 bits.
REQ-003 SHALL have parameter AWID, default 32, meaning address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss  in  1  level request to fill the line holding miss_adr.
- miss_adr  in  AWID  missing fetch address.
- busy  out  1  fill in progress (state not IDLE).
- done  out  1  one-cycle pulse, fill completed.
- err  out  1  one-cycle pulse, fill aborted.
- mreq  out  1  memory read request.
- madr  out  AWID  beat address, 16-byte aligned.
- mack  in  1  beat accepted, data valid this cycle.
- merr  in  1  bus error, qualified by mack.
- mdat  in  128  beat data.
- tag_wr  out  1  tag write strobe to the ictag stage.
- tag_ip  out  AWID  line address to the ictag stage, bits [5:0] zero.
- tag_way  out  2  victim way to the ictag stage.
- line_wr  out  1  data-array write strobe, coincident with tag_wr.
- line_dat  out  512  assembled line, beat 0 in bits [127:0].

Function
REQ-006 SHALL implement states IDLE, FETCH, WRITE, DONE.
REQ-007 In IDLE with miss=1, SHALL latch miss_adr[AWID-1:6] as line address, clear beat count, and enter FETCH next cycle.
REQ-008 SHALL ignore miss in any state other than IDLE.
REQ-009 In FETCH, SHALL hold mreq=1 with madr = {line address, beat[1:0], 4'h0}.
REQ-010 On mack=1 and merr=0 in FETCH, SHALL store mdat into line_dat slice [beat*128 +: 128] and increment beat.
REQ-011 mreq SHALL remain high between beats; one mack consumes exactly one beat.
REQ-012 After the mack of beat 3, SHALL enter WRITE; the beat counter wraps 3->0.
REQ-013 On mack=1 and merr=1 in FETCH, SHALL drop mreq next cycle, pulse err one cycle, enter IDLE, and issue no tag_wr or line_wr.
REQ-014 In WRITE, SHALL assert tag_wr and line_wr for exactly one cycle.
REQ-015 In WRITE, tag_ip SHALL equal {line address, 6'h0} and tag_way SHALL equal the victim way.
REQ-016 Victim way SHALL come from a per-set 2-bit round-robin pointer array of LINES entries, read at miss acceptance.
REQ-017 In WRITE, SHALL advance that set's pointer by 1 modulo WAYS (3->0).
REQ-018 In DONE, SHALL pulse done one cycle and return to IDLE.
REQ-019 Minimum latency SHALL be miss accept to tag_wr = 6 cycles with zero-wait mack, and miss accept to done = 7 cycles.
REQ-020 busy SHALL be 1 in FETCH, WRITE and DONE.
REQ-021 A miss held high through DONE SHALL start a new fill from IDLE on the following cycle.

Reset
REQ-022 rst_n=0 SHALL force IDLE from any state, including mid-FETCH.
REQ-023 Reset values SHALL be: mreq=0, busy=0, done=0, err=0, tag_wr=0, line_wr=0, madr=0, tag_ip=0, tag_way=0, line_dat=0, beat=0.
REQ-024 Reset SHALL zero all round-robin pointers.
REQ-025 A mack arriving in the first cycle after reset release SHALL be ignored.

Structure
REQ-026 State enum, beat width, BEAT_BYTES=16 and LINE_BYTES=64 SHALL reside in Thor2022_pkg.
REQ-027 The round-robin pointer array SHALL be one sub-module, Thor2022_icvictim (set index in, way out, advance strobe).

Verification
REQ-028 Reset, then miss with miss_adr=32'h0000_1234 and zero-wait mack: madr sequence 1200, 1210, 1220, 1230; tag_wr with tag_ip=32'h0000_1200, tag_way=0; done follows one cycle later.
REQ-029 Four back-to-back fills to set 0x48: tag_way sequence 0,1,2,3; a fifth fill gives way 0 (wrap).
REQ-030 merr=1 with the beat-2 mack: err pulses once, tag_wr and line_wr never assert, and the next fill to that set uses an unchanged way.
REQ-031 Beats with mdat=128'hA..A, B..B, C..C, D..D and 2 wait cycles per beat: line_dat = {D,C,B,A}, and mreq stays high throughout FETCH.
REQ-032 rst_n=0 asserted after beat 1: mreq=0 and busy=0 immediately (asynchronous), no tag_wr, and the pointers read 0.
REQ-033 miss pulsed during FETCH: no second fill, and exactly one done.
